// File: rtl/seg_decode_if.sv
// Sel/seg display bus plus the decoded-frame result signals of seg_decode.
// master = the side driving the display bus, slave = the decoder.
interface seg_decode_if;
  logic [5:0]  sel;
  logic [7:0]  seg;
  logic [23:0] data_out;
  logic [5:0]  dp_out;
  logic [5:0]  blank_out;
  logic [5:0]  digit_err;
  logic        frame_valid;
  logic        sel_err;

  modport master (
    output sel, seg,
    input  data_out, dp_out, blank_out, digit_err, frame_valid, sel_err
  );

  modport slave (
    input  sel, seg,
    output data_out, dp_out, blank_out, digit_err, frame_valid, sel_err
  );
endinterface

// File: rtl/seg_decode.sv
// Seven-segment bus monitor: debounces each sel/seg value and decodes it to a hex digit.
// Reassembles a 6-digit frame from a static or a scanned display.
module seg_decode #(
  parameter int STABLE_CYC = 16,
  parameter int CNT_W      = 5
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  seg_decode_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(STABLE_CYC - 1);

  // Result layout: {err, blank, nibble}
  function automatic logic [5:0] seg_to_digit(input logic [6:0] pat);
    logic [5:0] res;
    case (pat)
      7'h40:   res = {2'b00, 4'h0};
      7'h79:   res = {2'b00, 4'h1};
      7'h24:   res = {2'b00, 4'h2};
      7'h30:   res = {2'b00, 4'h3};
      7'h19:   res = {2'b00, 4'h4};
      7'h12:   res = {2'b00, 4'h5};
      7'h02:   res = {2'b00, 4'h6};
      7'h78:   res = {2'b00, 4'h7};
      7'h00:   res = {2'b00, 4'h8};
      7'h10:   res = {2'b00, 4'h9};
      7'h08:   res = {2'b00, 4'hA};
      7'h03:   res = {2'b00, 4'hB};
      7'h46:   res = {2'b00, 4'hC};
      7'h21:   res = {2'b00, 4'hD};
      7'h06:   res = {2'b00, 4'hE};
      7'h0E:   res = {2'b00, 4'hF};
      7'h7F:   res = {2'b01, 4'h0};
      default: res = {2'b10, 4'h0};
    endcase
    return res;
  endfunction

  logic [5:0]       sel_r;
  logic [7:0]       seg_r;
  logic [13:0]      prev_r;
  logic [CNT_W-1:0] cnt_r;
  logic [5:0]       mask_r;
  logic [23:0]      nib_sh_r;
  logic [5:0]       dp_sh_r;
  logic [5:0]       blank_sh_r;
  logic [5:0]       err_sh_r;
  logic [23:0]      data_r;
  logic [5:0]       dp_r;
  logic [5:0]       blank_r;
  logic [5:0]       err_r;
  logic             frame_valid_r;
  logic             sel_err_r;

  logic [5:0]       dec_s;
  logic             same_s;
  logic             strobe_s;
  logic             onehot_s;
  logic             all_s;
  logic             zero_s;
  logic [5:0]       wr_mask_s;
  logic             multi_err_s;
  logic             frame_done_s;

  assign dec_s        = seg_to_digit(seg_r[6:0]);
  assign same_s       = ({sel_r, seg_r} == prev_r);
  // Only the CNT_HIT -> CNT_MAX step fires; a saturated counter never re-captures
  assign strobe_s     = same_s && (cnt_r == CNT_HIT);
  assign zero_s       = (sel_r == 6'h00);
  assign all_s        = (sel_r == 6'h3F);
  assign onehot_s     = !zero_s && ((sel_r & (sel_r - 6'd1)) == 6'h00);
  assign multi_err_s  = strobe_s && !zero_s && !onehot_s && !all_s;
  assign frame_done_s = (mask_r == 6'h3F);

  // Slots written by this cycle's capture strobe
  always_comb begin
    wr_mask_s = 6'h00;
    if (strobe_s && all_s) begin
      wr_mask_s = 6'h3F;
    end else if (strobe_s && onehot_s) begin
      wr_mask_s = sel_r;
    end else begin
      wr_mask_s = 6'h00;
    end
  end

  // Input registers and stability counter
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sel_r  <= 6'h00;
      seg_r  <= 8'h00;
      prev_r <= 14'h0000;
      cnt_r  <= '0;
    end else begin
      sel_r  <= bus.sel;
      seg_r  <= bus.seg;
      prev_r <= {sel_r, seg_r};
      if (!same_s) begin
        cnt_r <= '0;
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Shadow slots and capture mask; a strobe coinciding with frame completion keeps its bit
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mask_r     <= 6'h00;
      nib_sh_r   <= 24'h000000;
      dp_sh_r    <= 6'h00;
      blank_sh_r <= 6'h00;
      err_sh_r   <= 6'h00;
    end else begin
      if (frame_done_s) begin
        mask_r <= wr_mask_s;
      end else begin
        mask_r <= mask_r | wr_mask_s;
      end
      for (int i = 0; i < 6; i++) begin
        if (wr_mask_s[i]) begin
          nib_sh_r[4*i +: 4] <= dec_s[3:0];
          dp_sh_r[i]         <= ~seg_r[7];
          blank_sh_r[i]      <= dec_s[4];
          err_sh_r[i]        <= dec_s[5];
        end
      end
    end
  end

  // Frame outputs and one-cycle status pulses
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      data_r        <= 24'h000000;
      dp_r          <= 6'h00;
      blank_r       <= 6'h00;
      err_r         <= 6'h00;
      frame_valid_r <= 1'b0;
      sel_err_r     <= 1'b0;
    end else begin
      frame_valid_r <= frame_done_s;
      sel_err_r     <= multi_err_s;
      if (frame_done_s) begin
        data_r  <= nib_sh_r;
        dp_r    <= dp_sh_r;
        blank_r <= blank_sh_r;
        err_r   <= err_sh_r;
      end
    end
  end

  assign bus.data_out    = data_r;
  assign bus.dp_out      = dp_r;
  assign bus.blank_out   = blank_r;
  assign bus.digit_err   = err_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.sel_err     = sel_err_r;

endmodule
